// File: rtl/gouram_datatypes.sv
// rtl/gouram_datatypes.sv - shared Gouram trace types and arbiter constants
package gouram_datatypes;

  localparam int TDATA_WIDTH = 32;
  localparam int TRACE_BEATS = 4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] mem_addr;
    logic [31:0] mem_trans_time_start;
    logic [31:0] mem_trans_time_end;
  } trace_format;

  typedef enum logic {ARB_IDLE, ARB_SEND} arb_state_t;

endpackage

// File: rtl/gouram_rr_grant.sv
// rtl/gouram_rr_grant.sv - combinational two-way grant for the trace arbiter
// GOURAM_ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
module gouram_rr_grant (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic any_grant_o
);

`ifdef GOURAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    any_grant_o = req0_i | req1_i;
    grant_o     = req1_i & ~req0_i;
    if (req0_i && req1_i) begin
`ifdef GOURAM_ARB_FIXED_PRIO_EN
      grant_o = 1'b0;
`else
      grant_o = ~last_grant_i;
`endif
    end
  end

endmodule

// File: rtl/gouram_trace_arbiter.sv
// rtl/gouram_trace_arbiter.sv - two-port trace record arbiter and 4-beat serializer
// GOURAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority in gouram_rr_grant.
module gouram_trace_arbiter
  import gouram_datatypes::*;
#(
  parameter int NUM_BEATS = $bits(trace_format) / TDATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in0_valid,
  output logic                   in0_ready,
  input  trace_format            in0_rec,
  input  logic                   in1_valid,
  output logic                   in1_ready,
  input  trace_format            in1_rec,
  output logic                   tvalid,
  input  logic                   tready,
  output logic [TDATA_WIDTH-1:0] tdata,
  output logic                   tlast,
  output logic                   tsrc,
  output logic [31:0]            rec_count
);

  localparam int BEAT_W = $clog2(NUM_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  arb_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  trace_format       buf_q, buf_d;
  logic              tsrc_q, tsrc_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       rec_count_q, rec_count_d;

  logic grant, any_grant;
  logic beat_done, can_load, load;

  gouram_rr_grant u_grant (
    .req0_i       (in0_valid),
    .req1_i       (in1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_grant_o  (any_grant)
  );

  // Loading on the cycle the last beat is accepted keeps the stream fully busy.
  always_comb begin
    beat_done = (state_q == ARB_SEND) && tready && (beat_q == LAST_BEAT);
    can_load  = (state_q == ARB_IDLE) || beat_done;
    load      = rst_n && can_load && any_grant;
    in0_ready = load && !grant;
    in1_ready = load && grant;
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    buf_d        = buf_q;
    tsrc_d       = tsrc_q;
    last_grant_d = last_grant_q;
    rec_count_d  = rec_count_q;
    if (state_q == ARB_SEND && tready) begin
      beat_d = beat_q + 1'b1;
      if (beat_q == LAST_BEAT) begin
        rec_count_d = rec_count_q + 32'd1;
        state_d     = ARB_IDLE;
      end
    end
    if (load) begin
      buf_d        = grant ? in1_rec : in0_rec;
      tsrc_d       = grant;
      last_grant_d = grant;
      beat_d       = '0;
      state_d      = ARB_SEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      beat_q       <= '0;
      buf_q        <= '0;
      tsrc_q       <= 1'b0;
      last_grant_q <= 1'b1;
      rec_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      buf_q        <= buf_d;
      tsrc_q       <= tsrc_d;
      last_grant_q <= last_grant_d;
      rec_count_q  <= rec_count_d;
    end
  end

  always_comb begin
    case (beat_q)
      BEAT_W'(0): tdata = buf_q.instruction;
      BEAT_W'(1): tdata = buf_q.mem_addr;
      BEAT_W'(2): tdata = buf_q.mem_trans_time_start;
      default:    tdata = buf_q.mem_trans_time_end;
    endcase
    tvalid    = (state_q == ARB_SEND);
    tlast     = tvalid && (beat_q == LAST_BEAT);
    tsrc      = tsrc_q;
    rec_count = rec_count_q;
  end

endmodule

// File: tb/tb_gouram_trace_arbiter.sv
// tb/tb_gouram_trace_arbiter.sv - self-checking bench for gouram_trace_arbiter
module tb_gouram_trace_arbiter;
  import gouram_datatypes::*;

  typedef struct packed { logic src; trace_format rec; } out_t;

`ifdef GOURAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in0_valid, in0_ready, in1_valid, in1_ready;
  trace_format in0_rec, in1_rec;
  logic tvalid, tready, tlast, tsrc;
  logic [31:0] tdata, rec_count;

  always #5 clk = ~clk;

  gouram_trace_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_rec(in0_rec),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_rec(in1_rec),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tlast(tlast),
    .tsrc(tsrc), .rec_count(rec_count)
  );

  int compared = 0, mismatched = 0, cyc = 0;
  trace_format q0[$], q1[$];
  out_t got[$];
  int beat_cyc[$];
  int bad_ready = 0, both_ready = 0, r1_cnt = 0, framing_err = 0;
  logic [31:0] part [4];
  int pidx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Producers hold valid/record until accepted; monitor rebuilds records from beats.
  initial begin : producer
    bit a0, a1;
    trace_format r;
    out_t o;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_rec = '0; in1_rec = '0;
    forever begin
      @(negedge clk);
      a0 = 1'b0; a1 = 1'b0;
      if (!rst_n) pidx = 0;
      else begin
        if (in0_ready && in1_ready) both_ready++;
        if (in1_ready) r1_cnt++;
        if ((in0_ready || in1_ready) && tvalid && !(tlast && tready)) bad_ready++;
        a0 = in0_valid && in0_ready;
        a1 = in1_valid && in1_ready;
        if (tvalid && tready) begin
          beat_cyc.push_back(cyc);
          if (tlast != (pidx == 3)) framing_err++;
          part[pidx & 3] = tdata;
          if (tlast || pidx == 3) begin
            r.instruction = part[0]; r.mem_addr = part[1];
            r.mem_trans_time_start = part[2]; r.mem_trans_time_end = part[3];
            o.src = tsrc; o.rec = r;
            got.push_back(o);
            pidx = 0;
          end else pidx++;
        end
      end
      @(posedge clk); #1;
      if (a0 && q0.size() > 0) q0.delete(0);
      if (a1 && q1.size() > 0) q1.delete(0);
      in0_valid = (q0.size() > 0);
      if (in0_valid) in0_rec = q0[0];
      in1_valid = (q1.size() > 0);
      if (in1_valid) in1_rec = q1[0];
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  function automatic trace_format mk_rec();
    trace_format r;
    r.instruction = $urandom; r.mem_addr = $urandom;
    r.mem_trans_time_start = $urandom; r.mem_trans_time_end = $urandom;
    return r;
  endfunction

  task automatic wait_recs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      samp();
      if (got.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle();
    tready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      samp();
      if (!tvalid && q0.size() == 0 && q1.size() == 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tready = 1'b1;
    q0.push_back(mk_rec()); q1.push_back(mk_rec());
    repeat (3) step();
    samp();
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    compared++; if (tdata !== 32'h0) begin mismatched++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
    compared++; if (tlast !== 1'b0) begin mismatched++; $display("FAIL reset_tlast: got %b expected 0", tlast); end
    compared++; if (tsrc !== 1'b0) begin mismatched++; $display("FAIL reset_tsrc: got %b expected 0", tsrc); end
    compared++; if (rec_count !== 32'h0) begin mismatched++; $display("FAIL reset_rec_count: got %h expected 0", rec_count); end
    compared++; if ({in0_ready, in1_ready} !== 2'b00) begin mismatched++; $display("FAIL reset_ready: got %b expected 00", {in0_ready, in1_ready}); end
    q0.delete(); q1.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    bad_ready = 0; both_ready = 0; framing_err = 0;
  endtask

  task automatic test_round_robin();
    trace_format p0[$], p1[$];
    int exp_src[8];
    bit last, ok;
    int c0, c1, n1, exp_n1, base, i0, i1;
    for (int k = 0; k < 4; k++) begin p0.push_back(mk_rec()); p1.push_back(mk_rec()); end
    got.delete(); beat_cyc.delete(); r1_cnt = 0; base = rec_count;
    // Both producers stay valid: grant alternation is the only thing steering order.
    last = 1'b1; c0 = 4; c1 = 4; exp_n1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (c0 > 0 && c1 > 0) exp_src[k] = FIXED ? 0 : int'(!last);
      else exp_src[k] = (c0 > 0) ? 0 : 1;
      last = exp_src[k][0];
      if (exp_src[k] == 0) c0--; else c1--;
      if (k < 4 && exp_src[k] == 1) exp_n1++;
    end
    foreach (p0[k]) begin q0.push_back(p0[k]); q1.push_back(p1[k]); end
    wait_recs(3, 100, ok);
    n1 = r1_cnt;
    wait_recs(4, 100, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL rr_timeout: got %0d records expected 4", got.size()); end
    compared++; if (n1 != exp_n1) begin mismatched++; $display("FAIL rr_in1_ready: got %0d expected %0d", n1, exp_n1); end
    if (ok) begin
      compared++;
      if (beat_cyc[15] - beat_cyc[0] != 15) begin mismatched++; $display("FAIL rr_no_idle: got span %0d expected 15", beat_cyc[15] - beat_cyc[0]); end
    end
    step();
    compared++; if (rec_count !== 32'(base + 4)) begin mismatched++; $display("FAIL rr_rec_count: got %0d expected %0d", rec_count, base + 4); end
    wait_recs(8, 200, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL rr_drain: got %0d records expected 8", got.size()); end
    i0 = 0; i1 = 0;
    for (int k = 0; k < got.size() && k < 8; k++) begin
      compared++;
      if (got[k].src !== exp_src[k][0]) begin mismatched++; $display("FAIL rr_src[%0d]: got %0d expected %0d", k, got[k].src, exp_src[k]); end
      compared++;
      if (got[k].src == 1'b0 && i0 < 4) begin
        if (got[k].rec !== p0[i0]) begin mismatched++; $display("FAIL rr_data[%0d]: got %h expected %h", k, got[k].rec, p0[i0]); end
        i0++;
      end else if (got[k].src == 1'b1 && i1 < 4) begin
        if (got[k].rec !== p1[i1]) begin mismatched++; $display("FAIL rr_data[%0d]: got %h expected %h", k, got[k].rec, p1[i1]); end
        i1++;
      end else begin mismatched++; $display("FAIL rr_data[%0d]: got extra record from port %0d expected none", k, got[k].src); end
    end
  endtask

  task automatic test_single();
    trace_format r;
    bit ok;
    int base;
    wait_idle();
    got.delete(); beat_cyc.delete(); framing_err = 0; base = rec_count;
    r.instruction = 32'h0000_0013; r.mem_addr = 32'h0000_1000;
    r.mem_trans_time_start = 32'd5; r.mem_trans_time_end = 32'd9;
    q0.push_back(r);
    wait_recs(1, 50, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL single_timeout: got %0d records expected 1", got.size()); end
    if (ok) begin
      compared++; if (got[0].rec !== r) begin mismatched++; $display("FAIL single_data: got %h expected %h", got[0].rec, r); end
      compared++; if (got[0].src !== 1'b0) begin mismatched++; $display("FAIL single_tsrc: got %b expected 0", got[0].src); end
      compared++; if (beat_cyc[3] - beat_cyc[0] != 3) begin mismatched++; $display("FAIL single_consecutive: got span %0d expected 3", beat_cyc[3] - beat_cyc[0]); end
    end
    compared++; if (framing_err != 0) begin mismatched++; $display("FAIL single_tlast: got %0d misplaced expected 0", framing_err); end
    step();
    compared++; if (rec_count !== 32'(base + 1)) begin mismatched++; $display("FAIL single_rec_count: got %0d expected %0d", rec_count, base + 1); end
  endtask

  task automatic test_backpressure();
    trace_format a, b;
    bit ok;
    wait_idle();
    got.delete(); beat_cyc.delete(); bad_ready = 0;
    a = mk_rec(); b = mk_rec();
    q0.push_back(a);
    for (int i = 0; i < 50 && beat_cyc.size() < 1; i++) samp();
    step();
    tready = 1'b0;
    q1.push_back(b);
    for (int k = 0; k < 3; k++) begin
      samp();
      compared++;
      if (tvalid !== 1'b1 || tdata !== a.mem_addr) begin
        mismatched++; $display("FAIL bp_hold[%0d]: got valid %b data %h expected 1 %h", k, tvalid, tdata, a.mem_addr);
      end
      step();
    end
    tready = 1'b1;
    wait_recs(2, 50, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL bp_timeout: got %0d records expected 2", got.size()); end
    if (ok) begin
      compared++; if (got[0].rec !== a) begin mismatched++; $display("FAIL bp_data: got %h expected %h", got[0].rec, a); end
      compared++; if (beat_cyc[3] - beat_cyc[0] != 6) begin mismatched++; $display("FAIL bp_late: got span %0d expected 6", beat_cyc[3] - beat_cyc[0]); end
      compared++; if (beat_cyc[4] - beat_cyc[3] != 1) begin mismatched++; $display("FAIL bp_overlap: got gap %0d expected 1", beat_cyc[4] - beat_cyc[3]); end
      compared++; if (got[1].rec !== b || got[1].src !== 1'b1) begin mismatched++; $display("FAIL bp_second: got %h/%b expected %h/1", got[1].rec, got[1].src, b); end
    end
    compared++; if (bad_ready != 0) begin mismatched++; $display("FAIL bp_early_ready: got %0d expected 0", bad_ready); end
  endtask

  task automatic test_reset_mid();
    trace_format a, c0, c1;
    bit ok;
    wait_idle();
    got.delete(); beat_cyc.delete();
    a = mk_rec();
    q0.push_back(a);
    for (int i = 0; i < 50 && beat_cyc.size() < 2; i++) samp();
    step();
    compared++; if (tdata !== a.mem_trans_time_start) begin mismatched++; $display("FAIL rmid_beat2: got %h expected %h", tdata, a.mem_trans_time_start); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("FAIL rmid_tvalid: got %b expected 0", tvalid); end
    compared++; if (rec_count !== 32'h0) begin mismatched++; $display("FAIL rmid_rec_count: got %h expected 0", rec_count); end
    samp();
    got.delete(); beat_cyc.delete(); q0.delete(); q1.delete(); framing_err = 0;
    c0 = mk_rec(); c1 = mk_rec();
    q0.push_back(c0); q1.push_back(c1);
    step(); step();
    rst_n = 1'b1;
    wait_recs(2, 50, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL rmid_timeout: got %0d records expected 2", got.size()); end
    if (ok) begin
      compared++; if (got[0].src !== 1'b0 || got[0].rec !== c0) begin mismatched++; $display("FAIL rmid_first: got %h/%b expected %h/0", got[0].rec, got[0].src, c0); end
      compared++; if (got[1].src !== 1'b1 || got[1].rec !== c1) begin mismatched++; $display("FAIL rmid_second: got %h/%b expected %h/1", got[1].rec, got[1].src, c1); end
    end
    compared++; if (framing_err != 0) begin mismatched++; $display("FAIL rmid_framing: got %0d expected 0", framing_err); end
  endtask

  task automatic test_wrap();
    bit ok;
    wait_idle();
    got.delete();
    force dut.rec_count_q = 32'hFFFF_FFFF;
    samp();
    release dut.rec_count_q;
    samp();
    q1.push_back(mk_rec());
    wait_recs(1, 50, ok);
    step();
    compared++; if (rec_count !== 32'h0) begin mismatched++; $display("FAIL wrap: got %h expected 0", rec_count); end
  endtask

  task automatic test_random();
    trace_format p0[$], p1[$];
    int n0, n1, i0, i1, base;
    n0 = 0; n1 = 0;
    wait_idle();
    got.delete(); bad_ready = 0; both_ready = 0; framing_err = 0; base = rec_count;
    for (int c = 0; c < 3000 && got.size() < 16; c++) begin
      step();
      tready = ($urandom_range(0, 3) != 0);
      if (n0 < 8 && $urandom_range(0, 2) == 0) begin p0.push_back(mk_rec()); q0.push_back(p0[n0]); n0++; end
      if (n1 < 8 && $urandom_range(0, 2) == 0) begin p1.push_back(mk_rec()); q1.push_back(p1[n1]); n1++; end
      samp();
    end
    tready = 1'b1;
    step();
    compared++; if (got.size() != 16) begin mismatched++; $display("FAIL rand_count: got %0d records expected 16", got.size()); end
    compared++; if (rec_count !== 32'(base + 16)) begin mismatched++; $display("FAIL rand_rec_count: got %0d expected %0d", rec_count, base + 16); end
    i0 = 0; i1 = 0;
    for (int k = 0; k < got.size(); k++) begin
      compared++;
      if (got[k].src == 1'b0 && i0 < p0.size()) begin
        if (got[k].rec !== p0[i0]) begin mismatched++; $display("FAIL rand_p0[%0d]: got %h expected %h", i0, got[k].rec, p0[i0]); end
        i0++;
      end else if (got[k].src == 1'b1 && i1 < p1.size()) begin
        if (got[k].rec !== p1[i1]) begin mismatched++; $display("FAIL rand_p1[%0d]: got %h expected %h", i1, got[k].rec, p1[i1]); end
        i1++;
      end else begin mismatched++; $display("FAIL rand_order[%0d]: got unexpected record from port %0d expected none", k, got[k].src); end
    end
    compared++; if (bad_ready != 0 || both_ready != 0) begin mismatched++; $display("FAIL rand_ready: got %0d/%0d bad expected 0/0", bad_ready, both_ready); end
    compared++; if (framing_err != 0) begin mismatched++; $display("FAIL rand_tlast: got %0d misplaced expected 0", framing_err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gouram_trace_arbiter.md
# gouram_trace_arbiter

Two-input round-robin arbiter and serializer for Gouram trace records. It sits between the two trace producers (port 0: instruction/IF tracker, port 1: memory/EX tracker) and the single 32-bit trace stream leaving the core. It grants one complete `trace_format` record at a time, buffers it, and emits it as four 32-bit beats on a valid/ready stream with `tlast` on the final beat.

## Interface
Parameters:
- `NUM_BEATS`, 4: beats per record; fixed at `$bits(trace_format)/TDATA_WIDTH`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in0_valid` in 1: port 0 record valid.
- `in0_ready` out 1: port 0 record accepted this cycle.
- `in0_rec` in `trace_format` (128): port 0 record.
- `in1_valid` in 1: port 1 record valid.
- `in1_ready` out 1: port 1 record accepted this cycle.
- `in1_rec` in `trace_format` (128): port 1 record.
- `tvalid` out 1: output beat valid.
- `tready` in 1: downstream accepts the beat.
- `tdata` out `TDATA_WIDTH` (32): beat payload.
- `tlast` out 1: final beat of a record.
- `tsrc` out 1: source port of the record being sent.
- `rec_count` out 32: records fully sent, wrapping.

## Operation
- State machine `IDLE` / `SEND`. There is also a 2-bit `beat` counter and a 128-bit record buffer.
- Load condition `can_load`:
  - true in `IDLE`;
  - true in `SEND` when `beat==3 && tready` (back-to-back overlap).
- Grant, combinational from valids and `last_grant`:
  - both valid: grant the port ≠ `last_grant`;
  - one valid: grant that port.
- `inN_ready = can_load && grant==N`. At most one ready is high per cycle. Ready never depends on `tready` except through `can_load`.
- On load:
  - buffer ← granted record;
  - `tsrc` ← granted port;
  - `last_grant` ← granted port;
  - `beat` ← 0;
  - state → `SEND`.
- Beat order:
  - 0: `instruction`;
  - 1: `mem_addr`;
  - 2: `mem_trans_time_start`;
  - 3: `mem_trans_time_end`, with `tlast=1`.
- In `SEND`, `beat` increments on `tvalid && tready`.
  - On beat 3 handshake, `rec_count` increments. It wraps 0xFFFF_FFFF → 0.
  - On beat 3 handshake, state → `IDLE` unless a load occurs the same cycle. In that case state stays `SEND` and `beat` returns to 0.
- `tvalid = (state==SEND)`. `tdata`, `tlast` and `tsrc` are held stable while `tvalid && !tready`.
- A producer must hold `inN_valid` and `inN_rec` until its ready. A request is never dropped.

## Timing
- Reset values:
  - state `IDLE`, `beat` 0, buffer 0;
  - `tvalid` 0, `tdata` 0, `tlast` 0, `tsrc` 0, `rec_count` 0;
  - `last_grant` 1, so port 0 wins the first tie;
  - `in0_ready` and `in1_ready` forced 0 while `rst_n` is low.
- Latency: a record loaded at edge T presents beat 0 from cycle T+1.
- With `tready` tied 1: beats are sent at T+1..T+4, the next load happens at T+4, and its beat 0 appears at T+5. That is 100% stream utilisation.
- Backpressure: each low `tready` cycle delays all remaining beats by one. Load overlap happens only in the cycle where beat 3 is accepted.
- Reset mid-record: the buffered record is discarded, `tvalid` drops immediately (asynchronously), and no partial-record recovery takes place.
- Simultaneous valids every slot: grants strictly alternate 0,1,0,1…

## Configuration
- `GOURAM_ARB_FIXED_PRIO_EN` defined:
  - port 0 always wins ties;
  - `last_grant` is ignored (still updated, unused);
  - port 1 can starve.
- Undefined (default): round-robin as above.

## Structure
- Add to `gouram_datatypes`:
  - `localparam TRACE_BEATS = 4`;
  - `typedef enum logic {ARB_IDLE, ARB_SEND} arb_state_t`.
- Reuse the existing `trace_format` typedef; do not redeclare it.
- One sub-module: `gouram_rr_grant`. It is the combinational 2-way grant (valids, `last_grant`, fixed-prio macro → grant index, any_grant). Everything else stays in `gouram_trace_arbiter`.

## Test plan
- **Single record, `tready`=1:**
  - Stimulus: port 0 record {0x0000_0013, 0x0000_1000, 5, 9}.
  - Required: beats 0x13, 0x1000, 5, 9 on four consecutive cycles; `tlast` only on the 4th; `tsrc`=0; `rec_count`=1.
- **Tie, round-robin:**
  - Stimulus: both ports valid continuously with distinct records, 4 records.
  - Required: `tsrc` sequence 0,1,0,1; 16 beats with no idle cycle; `rec_count`=4.
- **Backpressure:**
  - Stimulus: `tready` low for 3 cycles during beat 1.
  - Required: `tdata`=`mem_addr` held stable all 3 cycles; record completes 3 cycles late; no ready to producers until beat 3 is accepted.
- **Reset mid-record:**
  - Stimulus: assert `rst_n`=0 during beat 2.
  - Required: `tvalid` 0 immediately, `rec_count` 0, and after release the next record starts at beat 0 with port 0 winning the tie.
- **Wrap:**
  - Stimulus: force `rec_count` to 0xFFFF_FFFF, then send one record.
  - Required: `rec_count`=0.
- **`GOURAM_ARB_FIXED_PRIO_EN` build:**
  - Stimulus: both ports valid for 3 records.
  - Required: `tsrc` 0,0,0 and `in1_ready` never asserted.
